// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl: run sequencer for the 8x8 systolic TPU (feed, drain, diagonal write-back per batch).
// Define TPU_CYCLE_CNT_EN to add the saturating 16-bit cycle_cnt run-length output.
module tpu_seq_ctrl #(
    parameter int ARRAY_SIZE = 8,
    parameter int NUM_BATCH  = 3,
    parameter int SKEW       = 3,
    parameter int DRAIN_CYC  = 16
) (
    input  logic        clk,
    input  logic        srstn,
    input  logic        tpu_start,
    output logic [9:0]  sram_raddr_w0,
    output logic [9:0]  sram_raddr_w1,
    output logic [9:0]  sram_raddr_d0,
    output logic [9:0]  sram_raddr_d1,
    output logic        array_en,
    output logic        array_clear,
    output logic [3:0]  diag_sel,
    output logic        sram_write_enable_a0,
    output logic        sram_write_enable_b0,
    output logic        sram_write_enable_c0,
    output logic [5:0]  sram_waddr_a,
    output logic [5:0]  sram_waddr_b,
    output logic [5:0]  sram_waddr_c,
`ifdef TPU_CYCLE_CNT_EN
    output logic        tpu_done,
    output logic [15:0] cycle_cnt
`else
    output logic        tpu_done
`endif
);
    localparam int FEED_LEN  = ARRAY_SIZE + SKEW;
    localparam int WRITE_LEN = 2 * ARRAY_SIZE - 1;

    typedef enum logic [2:0] {IDLE, FEED, DRAIN, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  batch_q, batch_d;
    logic        feed_d1_q, feed_d1_d;
    logic        in_feed, in_drain, in_write, busy, start_acc;
    logic [9:0]  base, raddr;

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            batch_q   <= '0;
            feed_d1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            batch_q   <= batch_d;
            feed_d1_q <= feed_d1_d;
        end
    end

    assign in_feed   = (state_q == FEED);
    assign in_drain  = (state_q == DRAIN);
    assign in_write  = (state_q == WRITE);
    assign busy      = in_feed || in_drain || in_write;
    assign start_acc = tpu_start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        batch_d   = batch_q;
        feed_d1_d = in_feed;
        case (state_q)
            IDLE, DONE: begin
                if (tpu_start) begin
                    state_d = FEED;
                    cnt_d   = '0;
                    batch_d = '0;
                end
            end
            FEED: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(FEED_LEN - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(DRAIN_CYC - 1)) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(WRITE_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = (batch_q == 2'(NUM_BATCH - 1)) ? DONE : FEED;
                    batch_d = (batch_q == 2'(NUM_BATCH - 1)) ? batch_q : batch_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // DRAIN keeps presenting the final feed address so the SRAM outputs stay stable
    always_comb begin
        base                 = 10'(batch_q) * 10'(ARRAY_SIZE);
        raddr                = in_feed ? base + 10'(cnt_q) : in_drain ? base + 10'(FEED_LEN - 1) : 10'd0;
        sram_raddr_w0        = raddr;
        sram_raddr_w1        = raddr;
        sram_raddr_d0        = raddr;
        sram_raddr_d1        = raddr;
        array_en             = feed_d1_q;
        array_clear          = in_feed && (cnt_q == 6'd0);
        diag_sel             = in_write ? cnt_q[3:0] : 4'd0;
        sram_write_enable_a0 = !(in_write && batch_q == 2'd0);
        sram_write_enable_b0 = !(in_write && batch_q == 2'd1);
        sram_write_enable_c0 = !(in_write && batch_q == 2'd2);
        sram_waddr_a         = (in_write && batch_q == 2'd0) ? cnt_q : 6'd0;
        sram_waddr_b         = (in_write && batch_q == 2'd1) ? cnt_q : 6'd0;
        sram_waddr_c         = (in_write && batch_q == 2'd2) ? cnt_q : 6'd0;
        tpu_done             = (state_q == DONE);
    end

`ifdef TPU_CYCLE_CNT_EN
    logic [15:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        cycle_cnt_d = start_acc ? 16'd0 : (busy && cycle_cnt_q != 16'hFFFF) ? cycle_cnt_q + 16'd1 : cycle_cnt_q;
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) cycle_cnt_q <= '0;
        else        cycle_cnt_q <= cycle_cnt_d;
    end

    assign cycle_cnt = cycle_cnt_q;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, busy, start_acc};
`endif
endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// tb_tpu_seq_ctrl: directed/randomized run sequence for tpu_seq_ctrl checked against a cycle-index model.
// Also exercises cycle_cnt when built with TPU_CYCLE_CNT_EN.
module tb_tpu_seq_ctrl;
    localparam int FEED_LEN  = 11;
    localparam int DRAIN_LEN = 16;
    localparam int WR_LEN    = 15;
    localparam int PER       = FEED_LEN + DRAIN_LEN + WR_LEN;
    localparam int TOTAL     = 3 * PER;

    logic        clk = 1'b0;
    logic        srstn;
    logic        tpu_start;
    logic [9:0]  w0, w1, d0, d1;
    logic        array_en, array_clear;
    logic [3:0]  diag_sel;
    logic        we_a, we_b, we_c;
    logic [5:0]  wa, wb, wc;
    logic        tpu_done;
`ifdef TPU_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int mem   [3][16];
    int gold  [3][16];
    int wcnt  [3];

    tpu_seq_ctrl dut (
        .clk(clk), .srstn(srstn), .tpu_start(tpu_start),
        .sram_raddr_w0(w0), .sram_raddr_w1(w1), .sram_raddr_d0(d0), .sram_raddr_d1(d1),
        .array_en(array_en), .array_clear(array_clear), .diag_sel(diag_sel),
        .sram_write_enable_a0(we_a), .sram_write_enable_b0(we_b), .sram_write_enable_c0(we_c),
        .sram_waddr_a(wa), .sram_waddr_b(wb), .sram_waddr_c(wc),
`ifdef TPU_CYCLE_CNT_EN
        .tpu_done(tpu_done), .cycle_cnt(cycle_cnt)
`else
        .tpu_done(tpu_done)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [67:0] obs_vec();
        return {w0, w1, d0, d1, array_en, array_clear, diag_sel, we_a, we_b, we_c, wa, wb, wc, tpu_done};
    endfunction

    // k = edges since the start was accepted (0 = first FEED cycle); k<0 idle after reset, k>=TOTAL done
    function automatic logic [67:0] exp_vec(input int k);
        int b, p;
        logic [9:0] ra;
        logic en, clr, dn;
        logic [3:0] dg;
        logic [2:0] we;
        logic [5:0] a0, a1, a2;
        ra = '0; en = 1'b0; clr = 1'b0; dg = '0; we = 3'b111; a0 = '0; a1 = '0; a2 = '0;
        dn = (k >= TOTAL);
        if (k >= 0 && k < TOTAL) begin
            b = k / PER;
            p = k % PER;
            if (p < FEED_LEN) ra = 10'(b * 8 + p);
            else if (p < FEED_LEN + DRAIN_LEN) ra = 10'(b * 8 + FEED_LEN - 1);
            en  = (p >= 1 && p <= FEED_LEN);
            clr = (p == 0);
            if (p >= FEED_LEN + DRAIN_LEN) begin
                dg = 4'(p - FEED_LEN - DRAIN_LEN);
                we[2 - b] = 1'b0;
                if (b == 0) a0 = 6'(dg);
                if (b == 1) a1 = 6'(dg);
                if (b == 2) a2 = 6'(dg);
            end
        end
        return {ra, ra, ra, ra, en, clr, dg, we, a0, a1, a2, dn};
    endfunction

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int n, input int k);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("gap%0d", i), obs_vec(), exp_vec(k));
            tick();
        end
    endtask

    // One run from IDLE/DONE; spur = cycle index of an ignored start pulse, abort_k = reset point
    task automatic run(input int spur, input int abort_k);
        for (int b = 0; b < 3; b++) begin
            wcnt[b] = 0;
            for (int a = 0; a < 16; a++) begin
                mem[b][a]  = -1;
                gold[b][a] = int'($urandom_range(0, 65535));
            end
        end
        tpu_start = 1'b1;
        tick();
        tpu_start = 1'b0;
        for (int k = 0; k <= TOTAL; k++) begin
            if (k == abort_k) begin
                srstn = 1'b0;
                #1;
                chk($sformatf("abort_k%0d", k), obs_vec(), exp_vec(-1));
`ifdef TPU_CYCLE_CNT_EN
                chk_int("abort_cyc", int'(cycle_cnt), 0);
`endif
                repeat (2) tick();
                chk("abort_hold", obs_vec(), exp_vec(-1));
                srstn = 1'b1;
                tick();
                return;
            end
            chk($sformatf("k%0d", k), obs_vec(), exp_vec(k));
`ifdef TPU_CYCLE_CNT_EN
            chk_int($sformatf("cyc_k%0d", k), int'(cycle_cnt), k);
`endif
            if (!we_a) begin mem[0][wa[3:0]] = gold[0][diag_sel]; wcnt[0]++; end
            if (!we_b) begin mem[1][wb[3:0]] = gold[1][diag_sel]; wcnt[1]++; end
            if (!we_c) begin mem[2][wc[3:0]] = gold[2][diag_sel]; wcnt[2]++; end
            tpu_start = (k == spur);
            tick();
        end
        tpu_start = 1'b0;
        chk("done_hold", obs_vec(), exp_vec(TOTAL + 1));
`ifdef TPU_CYCLE_CNT_EN
        chk_int("cyc_done", int'(cycle_cnt), TOTAL);
`endif
        for (int b = 0; b < 3; b++) begin
            chk_int($sformatf("wcnt%0d", b), wcnt[b], WR_LEN);
            for (int a = 0; a < WR_LEN; a++)
                chk_int($sformatf("mem%0d_%0d", b, a), mem[b][a], gold[b][a]);
        end
    endtask

    initial begin
        srstn     = 1'b0;
        tpu_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", obs_vec(), exp_vec(-1));
`ifdef TPU_CYCLE_CNT_EN
        chk_int("reset_cyc", int'(cycle_cnt), 0);
`endif
        srstn = 1'b1;
        tick();
        idle_gap(int'($urandom_range(1, 5)), -1);
        run(-1, -1);
        idle_gap(int'($urandom_range(1, 4)), TOTAL);
        run(40, -1);
        run(TOTAL - 1, -1);
        run(int'($urandom_range(1, TOTAL - 2)), -1);
        run(-1, PER + FEED_LEN + DRAIN_LEN + 5);
        idle_gap(int'($urandom_range(1, 4)), -1);
        run(-1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
